multi_byte_transmitter: RTL and testbench

Serialises one word of up to N_BYTES bytes into single-byte requests for the UART transmitter. It sits between the debug/control unit and the UART TX core.
Each request selects the byte count (1..N_BYTES) and the byte order. The block supports busy/drop signalling and a per-byte watchdog timeout.
It issues exactly one completion or abort pulse per accepted request.

---
 rtl/mbt_pkg.sv | 15 +
 rtl/tx_watchdog.sv | 30 +++
 rtl/multi_byte_transmitter.sv | 130 +++++++++++++
 tb/tb_multi_byte_transmitter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbt_pkg.sv
// rtl/mbt_pkg.sv - shared state and byte-order encodings for multi_byte_transmitter
package mbt_pkg;

    localparam int NB_STATE = 2;

    typedef enum logic [NB_STATE-1:0] {
        IDLE         = 2'd0,
        WAIT_TX_DONE = 2'd1,
        FINISH       = 2'd2
    } state_t;

    localparam logic LSB_FIRST = 1'b1;
    localparam logic MSB_FIRST = 1'b0;

endpackage

// File: rtl/tx_watchdog.sv
// rtl/tx_watchdog.sv - per-byte timeout counter; expire pulses when the count reaches TIMEOUT_CYCLES
module tx_watchdog #(
    parameter int NB_TIMEOUT     = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    logic [NB_TIMEOUT-1:0] count;
    logic [NB_TIMEOUT-1:0] count_next;

    // The clearing cycle itself counts as the first elapsed cycle.
    assign count_next = i_clear ? NB_TIMEOUT'(1) : count + 1'b1;

    always_ff @(posedge i_clock) begin
        if (i_reset || !i_enable) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign o_expire = (TIMEOUT_CYCLES != 0) && i_enable
                      && (count_next == NB_TIMEOUT'(TIMEOUT_CYCLES));

endmodule

// File: rtl/multi_byte_transmitter.sv
// rtl/multi_byte_transmitter.sv - serialises a word of up to N_BYTES bytes into single-byte UART requests
module multi_byte_transmitter #(
    parameter int   NB_BYTE        = 8,
    parameter int   N_BYTES        = 4,
    localparam int  NB_WORD        = NB_BYTE * N_BYTES,
    parameter int   NB_COUNT       = 3,
    parameter int   NB_TIMEOUT     = 16,
    parameter int   TIMEOUT_CYCLES = 50000
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [NB_WORD-1:0]  i_tx_data,
    input  logic                i_tx_start,
    input  logic [NB_COUNT-1:0] i_tx_n_bytes,
    input  logic                i_tx_lsb_first,
    input  logic                i_tx_done,
    output logic [NB_BYTE-1:0]  o_tx_data,
    output logic                o_tx_start,
    output logic                o_busy,
    output logic                o_done,
    output logic [NB_COUNT-1:0] o_done_n_bytes,
    output logic                o_timeout,
    output logic                o_req_dropped
);

    import mbt_pkg::*;

    state_t              state;
    logic [NB_WORD-1:0]  word_q;
    logic [NB_COUNT-1:0] n_q;
    logic [NB_COUNT-1:0] sent_q;
    logic                order_q;
    logic                count_ok;
    logic                wd_expire;

    assign count_ok = (i_tx_n_bytes != '0) && (i_tx_n_bytes <= NB_COUNT'(N_BYTES));

    // k is the position in the transmit sequence; returns the word byte sent at that position.
    function automatic logic [NB_BYTE-1:0] pick_byte(
        input logic [NB_WORD-1:0]  word,
        input logic [NB_COUNT-1:0] n,
        input logic                order,
        input logic [NB_COUNT-1:0] k
    );
        logic [NB_COUNT-1:0] idx;
        logic [NB_WORD-1:0]  shifted;
        idx = k;
        case (order)
            LSB_FIRST: idx = k;
            MSB_FIRST: idx = n - k - 1'b1;
        endcase
        shifted = word >> (NB_BYTE * int'(idx));
        return shifted[NB_BYTE-1:0];
    endfunction

    tx_watchdog #(
        .NB_TIMEOUT     (NB_TIMEOUT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_clear  (o_tx_start),
        .i_enable (state == WAIT_TX_DONE),
        .o_expire (wd_expire)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state          <= IDLE;
            word_q         <= '0;
            n_q            <= '0;
            sent_q         <= '0;
            order_q        <= 1'b0;
            o_tx_data      <= '0;
            o_tx_start     <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_done_n_bytes <= '0;
            o_timeout      <= 1'b0;
            o_req_dropped  <= 1'b0;
        end else begin
            o_tx_start     <= 1'b0;
            o_done         <= 1'b0;
            o_done_n_bytes <= '0;
            o_timeout      <= 1'b0;
            o_req_dropped  <= i_tx_start && !((state == IDLE) && count_ok);

            case (state)
                IDLE: begin
                    if (i_tx_start && count_ok) begin
                        word_q     <= i_tx_data;
                        n_q        <= i_tx_n_bytes;
                        order_q    <= i_tx_lsb_first;
                        sent_q     <= NB_COUNT'(1);
                        o_tx_data  <= pick_byte(i_tx_data, i_tx_n_bytes, i_tx_lsb_first, '0);
                        o_tx_start <= 1'b1;
                        o_busy     <= 1'b1;
                        state      <= WAIT_TX_DONE;
                    end
                end
                WAIT_TX_DONE: begin
                    // A done in the same cycle as our start belongs to the previous byte.
                    if (i_tx_done && !o_tx_start) begin
                        if (sent_q == n_q) begin
                            o_done         <= 1'b1;
                            o_done_n_bytes <= n_q;
                            o_busy         <= 1'b0;
                            state          <= FINISH;
                        end else begin
                            o_tx_data  <= pick_byte(word_q, n_q, order_q, sent_q);
                            sent_q     <= sent_q + 1'b1;
                            o_tx_start <= 1'b1;
                        end
                    end else if (wd_expire) begin
                        o_timeout <= 1'b1;
                        o_busy    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_byte_transmitter.sv
// tb/tb_multi_byte_transmitter.sv - self-checking bench for multi_byte_transmitter with a UART stub
module tb_multi_byte_transmitter;

    localparam int TO_CYCLES = 20;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic [31:0] i_tx_data;
    logic        i_tx_start;
    logic [2:0]  i_tx_n_bytes;
    logic        i_tx_lsb_first;
    logic        i_tx_done;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_busy;
    logic        o_done;
    logic [2:0]  o_done_n_bytes;
    logic        o_timeout;
    logic        o_req_dropped;

    logic stub_done = 1'b0;
    logic spur_done;
    assign i_tx_done = stub_done | spur_done;

    always #5 i_clock = ~i_clock;

    multi_byte_transmitter #(
        .NB_BYTE        (8),
        .N_BYTES        (4),
        .NB_COUNT       (3),
        .NB_TIMEOUT     (16),
        .TIMEOUT_CYCLES (TO_CYCLES)
    ) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_tx_data      (i_tx_data),
        .i_tx_start     (i_tx_start),
        .i_tx_n_bytes   (i_tx_n_bytes),
        .i_tx_lsb_first (i_tx_lsb_first),
        .i_tx_done      (i_tx_done),
        .o_tx_data      (o_tx_data),
        .o_tx_start     (o_tx_start),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_done_n_bytes (o_done_n_bytes),
        .o_timeout      (o_timeout),
        .o_req_dropped  (o_req_dropped)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge i_clock) cyc <= cyc + 1;

    // Observed activity, sampled at the falling edge.
    logic [7:0] mon_bytes[$];
    int         mon_cyc[$];
    int done_cnt = 0, done_n = 0, done_cyc = 0;
    int to_cnt = 0, to_cyc = 0, drop_cnt = 0, drop_cyc = 0;
    int busy_err = 0, pulse_err = 0;

    initial begin : monitor
        logic active, p_start, p_done, p_to, p_drop;
        active = 0; p_start = 0; p_done = 0; p_to = 0; p_drop = 0;
        forever begin
            @(negedge i_clock);
            if (i_reset) active = 0;
            if (active && !o_busy && !o_done && !o_timeout) busy_err++;
            if (o_tx_start) begin
                mon_bytes.push_back(o_tx_data);
                mon_cyc.push_back(cyc);
                active = 1;
            end
            if (o_done) begin done_cnt++; done_n = int'(o_done_n_bytes); done_cyc = cyc; active = 0; end
            if (o_timeout) begin to_cnt++; to_cyc = cyc; active = 0; end
            if (o_req_dropped) begin drop_cnt++; drop_cyc = cyc; end
            if ((o_tx_start && p_start) || (o_done && p_done) || (o_timeout && p_to)
                || (o_req_dropped && p_drop)) pulse_err++;
            p_start = o_tx_start; p_done = o_done; p_to = o_timeout; p_drop = o_req_dropped;
        end
    end

    // UART stub: answers each o_tx_start with one i_tx_done pulse stub_delay cycles later.
    int stub_delay   = 10;
    int stub_limit   = 1 << 30;
    int stub_answers = 0;

    initial begin : uart_stub
        int cd;
        cd = 0;
        forever begin
            @(negedge i_clock);
            stub_done = 1'b0;
            if (i_reset) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        stub_done = 1'b1;
                        stub_answers++;
                    end
                end
                if (o_tx_start && stub_answers < stub_limit) cd = stub_delay;
            end
        end
    end

    // Expected sequence from the byte-order rule: {count, bytes packed first-byte-highest}.
    function automatic logic [39:0] model_sig(input logic [31:0] d, input int n, input bit lsb);
        logic [7:0]      low[$];
        longint unsigned v;
        logic [31:0]     s;
        v = d;
        s = '0;
        for (int i = 0; i < n; i++) begin
            low.push_back(8'(v % 256));
            v = v / 256;
        end
        for (int i = 0; i < n; i++) s = (s << 8) | 32'(lsb ? low[i] : low[n-1-i]);
        return {8'(n), s};
    endfunction

    function automatic logic [39:0] got_sig(input int base);
        logic [31:0] s;
        s = '0;
        for (int i = base; i < mon_bytes.size(); i++) s = (s << 8) | 32'(mon_bytes[i]);
        return {8'(mon_bytes.size() - base), s};
    endfunction

    task automatic issue(input logic [31:0] d, input logic [2:0] n, input logic lsb);
        i_tx_data = d; i_tx_n_bytes = n; i_tx_lsb_first = lsb; i_tx_start = 1'b1;
        @(negedge i_clock);
        i_tx_start = 1'b0;
    endtask

    task automatic wait_end(input int base_d, input int base_t, output bit ok);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge i_clock);
            if (done_cnt > base_d || to_cnt > base_t) begin
                ok = 1;
                break;
            end
        end
        repeat (2) @(negedge i_clock);
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(negedge i_clock);
        n_cmp++;
        if ({o_tx_data, o_tx_start, o_busy, o_done, o_done_n_bytes, o_timeout, o_req_dropped} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %0h required 0", {o_tx_data, o_tx_start, o_busy, o_done, o_done_n_bytes, o_timeout, o_req_dropped});
        end
        i_reset = 1'b0;
        repeat (2) @(negedge i_clock);
        n_cmp++;
        if ({o_tx_start, o_busy, o_done, o_timeout, o_req_dropped} !== '0) begin
            n_err++; $display("FAIL idle_after_reset: got %0b required 0", {o_tx_start, o_busy, o_done, o_timeout, o_req_dropped});
        end
    endtask

    task automatic test_full_msb();
        int base, bd, bt, be, t0;
        bit ok;
        stub_delay = 10;
        base = mon_bytes.size(); bd = done_cnt; bt = to_cnt; be = busy_err; t0 = cyc;
        issue(32'hA1B2C3D4, 3'd4, 1'b0);
        wait_end(bd, bt, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL full_msb_end: no completion within budget"); end
        n_cmp++;
        if (got_sig(base) !== {8'd4, 32'hA1B2C3D4}) begin
            n_err++; $display("FAIL full_msb_bytes: got %h required %h", got_sig(base), {8'd4, 32'hA1B2C3D4});
        end
        n_cmp++;
        if (mon_cyc.size() <= base || mon_cyc[base] != t0 + 1) begin
            n_err++; $display("FAIL full_msb_latency: first start not at cycle %0d", t0 + 1);
        end
        n_cmp++; if (done_cnt - bd != 1) begin n_err++; $display("FAIL full_msb_done_cnt: got %0d required 1", done_cnt - bd); end
        n_cmp++; if (done_n != 4) begin n_err++; $display("FAIL full_msb_done_n: got %0d required 4", done_n); end
        n_cmp++; if (busy_err != be) begin n_err++; $display("FAIL full_msb_busy: busy low %0d cycles, required 0", busy_err - be); end
    endtask

    task automatic test_partial();
        logic [2:0]  nn[3] = '{3'd2, 3'd2, 3'd1};
        logic        ll[3] = '{1'b1, 1'b0, 1'b1};
        logic [39:0] ex[3] = '{{8'd2, 32'h4433}, {8'd2, 32'h3344}, {8'd1, 32'h44}};
        int base, bd, bt;
        bit ok;
        for (int c = 0; c < 3; c++) begin
            base = mon_bytes.size(); bd = done_cnt; bt = to_cnt;
            issue(32'h11223344, nn[c], ll[c]);
            wait_end(bd, bt, ok);
            n_cmp++;
            if (!ok || got_sig(base) !== ex[c]) begin
                n_err++; $display("FAIL partial_%0d_bytes: got %h required %h", c, got_sig(base), ex[c]);
            end
            n_cmp++;
            if (done_cnt - bd != 1 || done_n != int'(nn[c])) begin
                n_err++; $display("FAIL partial_%0d_done: got cnt %0d n %0d required 1 and %0d", c, done_cnt - bd, done_n, nn[c]);
            end
        end
    endtask

    task automatic test_drops();
        logic [2:0] bad[2] = '{3'd0, 3'd5};
        int base, bd, bt, dd, t0;
        bit ok;
        for (int c = 0; c < 2; c++) begin
            base = mon_bytes.size(); dd = drop_cnt; t0 = cyc;
            issue($urandom, bad[c], 1'b1);
            repeat (3) @(negedge i_clock);
            n_cmp++;
            if (drop_cnt - dd != 1 || drop_cyc != t0 + 1) begin
                n_err++; $display("FAIL drop_count_%0d: got %0d drops at %0d required 1 at %0d", bad[c], drop_cnt - dd, drop_cyc, t0 + 1);
            end
            n_cmp++;
            if (mon_bytes.size() != base || o_busy !== 1'b0) begin
                n_err++; $display("FAIL drop_quiet_%0d: got %0d starts busy %b required 0 and 0", bad[c], mon_bytes.size() - base, o_busy);
            end
        end
        base = mon_bytes.size(); bd = done_cnt; bt = to_cnt; dd = drop_cnt;
        issue(32'hCAFEF00D, 3'd3, 1'b1);
        repeat (4) @(negedge i_clock);
        t0 = cyc;
        issue(32'h12345678, 3'd4, 1'b0);
        wait_end(bd, bt, ok);
        n_cmp++;
        if (drop_cnt - dd != 1 || drop_cyc != t0 + 1) begin
            n_err++; $display("FAIL drop_busy: got %0d drops at %0d required 1 at %0d", drop_cnt - dd, drop_cyc, t0 + 1);
        end
        n_cmp++;
        if (!ok || got_sig(base) !== model_sig(32'hCAFEF00D, 3, 1'b1) || done_n != 3) begin
            n_err++; $display("FAIL drop_busy_bytes: got %h n %0d required %h n 3", got_sig(base), done_n, model_sig(32'hCAFEF00D, 3, 1'b1));
        end
    endtask

    task automatic test_watchdog();
        int base, bd, bt;
        bit ok;
        base = mon_bytes.size(); bd = done_cnt; bt = to_cnt;
        stub_delay = 10;
        stub_limit = stub_answers + 1;
        issue(32'h55AA6699, 3'd3, 1'b0);
        wait_end(bd, bt, ok);
        n_cmp++;
        if (!ok || to_cnt - bt != 1 || done_cnt != bd) begin
            n_err++; $display("FAIL wd_pulse: got timeouts %0d dones %0d required 1 and 0", to_cnt - bt, done_cnt - bd);
        end
        n_cmp++;
        if (got_sig(base) !== {8'd2, 32'hAA66}) begin
            n_err++; $display("FAIL wd_bytes: got %h required %h", got_sig(base), {8'd2, 32'hAA66});
        end
        n_cmp++;
        if (mon_cyc.size() == 0 || to_cyc - mon_cyc[mon_cyc.size()-1] != TO_CYCLES) begin
            n_err++; $display("FAIL wd_latency: got %0d cycles required %0d", to_cyc - mon_cyc[mon_cyc.size()-1], TO_CYCLES);
        end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL wd_busy: got %b required 0", o_busy); end
        stub_limit = 1 << 30;
        base = mon_bytes.size(); bd = done_cnt; bt = to_cnt;
        issue(32'h000000E7, 3'd1, 1'b0);
        wait_end(bd, bt, ok);
        n_cmp++;
        if (!ok || got_sig(base) !== {8'd1, 32'hE7} || done_cnt - bd != 1) begin
            n_err++; $display("FAIL wd_recover: got %h required %h", got_sig(base), {8'd1, 32'hE7});
        end
    endtask

    task automatic test_reset_mid();
        int base, bd, bt;
        bit ok;
        logic [31:0] d;
        base = mon_bytes.size(); bd = done_cnt; bt = to_cnt;
        issue(32'hDEADBEEF, 3'd4, 1'b1);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clock);
            if (mon_bytes.size() >= base + 2) begin ok = 1; break; end
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rst_mid_progress: second byte not seen"); end
        repeat (2) @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);
        n_cmp++;
        if ({o_tx_data, o_tx_start, o_busy, o_done, o_done_n_bytes, o_timeout, o_req_dropped} !== '0) begin
            n_err++; $display("FAIL rst_mid_outputs: got %0h required 0", {o_tx_data, o_tx_start, o_busy, o_done, o_done_n_bytes, o_timeout, o_req_dropped});
        end
        @(negedge i_clock);
        i_reset = 1'b0;
        repeat (40) @(negedge i_clock);
        n_cmp++;
        if (done_cnt != bd || to_cnt != bt || mon_bytes.size() != base + 2) begin
            n_err++; $display("FAIL rst_mid_quiet: got dones %0d timeouts %0d bytes %0d required 0 0 2", done_cnt - bd, to_cnt - bt, mon_bytes.size() - base);
        end
        d = $urandom;
        base = mon_bytes.size();
        issue(d, 3'd4, 1'b1);
        wait_end(bd, bt, ok);
        n_cmp++;
        if (!ok || got_sig(base) !== model_sig(d, 4, 1'b1) || done_n != 4) begin
            n_err++; $display("FAIL rst_mid_fresh: got %h required %h", got_sig(base), model_sig(d, 4, 1'b1));
        end
    endtask

    task automatic test_back_to_back();
        int base, bd, bt, dd, t0;
        bit ok;
        base = mon_bytes.size(); bd = done_cnt;
        repeat (3) begin
            spur_done = 1'b1; @(negedge i_clock);
            spur_done = 1'b0; @(negedge i_clock);
        end
        n_cmp++;
        if (mon_bytes.size() != base || done_cnt != bd || o_busy !== 1'b0) begin
            n_err++; $display("FAIL b2b_idle_done: got starts %0d dones %0d required 0 0", mon_bytes.size() - base, done_cnt - bd);
        end
        bt = to_cnt;
        issue(32'h0BADBEEF, 3'd2, 1'b1);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (o_done === 1'b1) begin ok = 1; break; end
            @(negedge i_clock);
        end
        spur_done = 1'b1;
        @(negedge i_clock);
        spur_done = 1'b0;
        n_cmp++;
        if (!ok || got_sig(base) !== {8'd2, 32'hEFBE}) begin
            n_err++; $display("FAIL b2b_first: got %h required %h", got_sig(base), {8'd2, 32'hEFBE});
        end
        base = mon_bytes.size(); dd = drop_cnt; bd = done_cnt; t0 = cyc;
        issue(32'h76543210, 3'd3, 1'b0);
        wait_end(bd, bt, ok);
        n_cmp++;
        if (drop_cnt != dd || mon_cyc.size() <= base || mon_cyc[base] != t0 + 1) begin
            n_err++; $display("FAIL b2b_accept: got drops %0d required 0, start expected at %0d", drop_cnt - dd, t0 + 1);
        end
        n_cmp++;
        if (!ok || got_sig(base) !== {8'd3, 32'h543210} || done_n != 3) begin
            n_err++; $display("FAIL b2b_second: got %h required %h", got_sig(base), {8'd3, 32'h543210});
        end
        bd = done_cnt;
        issue(32'h000000A5, 3'd1, 1'b1);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (o_done === 1'b1) begin ok = 1; break; end
            @(negedge i_clock);
        end
        base = mon_bytes.size(); dd = drop_cnt;
        issue(32'h11111111, 3'd1, 1'b1);
        repeat (4) @(negedge i_clock);
        n_cmp++;
        if (!ok || drop_cnt - dd != 1 || mon_bytes.size() != base) begin
            n_err++; $display("FAIL finish_drop: got drops %0d starts %0d required 1 0", drop_cnt - dd, mon_bytes.size() - base);
        end
    endtask

    task automatic test_random();
        int base, bd, bt, n;
        bit ok, l;
        logic [31:0] d;
        for (int it = 0; it < 12; it++) begin
            d = $urandom; n = $urandom_range(1, 4); l = 1'($urandom_range(0, 1));
            stub_delay = $urandom_range(1, 15);
            base = mon_bytes.size(); bd = done_cnt; bt = to_cnt;
            issue(d, 3'(n), l);
            wait_end(bd, bt, ok);
            n_cmp++;
            if (!ok || got_sig(base) !== model_sig(d, n, l)) begin
                n_err++; $display("FAIL rand_%0d_bytes: got %h required %h", it, got_sig(base), model_sig(d, n, l));
            end
            n_cmp++;
            if (done_cnt - bd != 1 || done_n != n || to_cnt != bt) begin
                n_err++; $display("FAIL rand_%0d_done: got cnt %0d n %0d required 1 and %0d", it, done_cnt - bd, done_n, n);
            end
        end
        n_cmp++;
        if (pulse_err != 0) begin n_err++; $display("FAIL pulse_width: got %0d wide pulses required 0", pulse_err); end
    endtask

    initial begin
        i_reset = 1'b1; i_tx_start = 1'b0; i_tx_data = '0; i_tx_n_bytes = '0;
        i_tx_lsb_first = 1'b0; spur_done = 1'b0;
        @(negedge i_clock);
        test_reset();
        test_full_msb();
        test_partial();
        test_drops();
        test_watchdog();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
